// File: rtl/key_en_gen.sv
// key_en_gen: debounces an active-low push button with a four-state filter FSM.
// It produces a one-clock key_flag on every confirmed press or release, a
// debounced key_state level, an en strobe EN_CYCLES clocks wide after each
// confirmed press, and a saturating 8-bit press counter.
//
// Handshake note: there is no valid/ready pairing here. key_flag is a
// one-clock qualifier for key_state, and en is a level strobe that fsm samples
// on every clock. Neither output waits for any acknowledge.
//
// Extra debug port: state_dbg exposes the filter FSM state
// (IDLE=0, FILTER0=1, DOWN=2, FILTER1=3).
module key_en_gen #(
  parameter int CNT_MAX   = 1_000_000,
  parameter int CNT_W     = 20,
  parameter int EN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       en,
  output logic       key_flag,
  output logic       key_state,
  output logic [7:0] press_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [3:0]       EN_LOAD  = 4'(EN_CYCLES);

  logic             key_s1, key_s, key_d;
  logic             nedge, pedge;
  logic [1:0]       boot_q;
  logic             armed;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             flag_nx, kstate_nx;
  logic             press;
  logic [3:0]       en_cnt;

  // Two-flop synchronizer plus one delay flop for edge detection; all preset to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s  <= 1'b1;
      key_d  <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s  <= key_s1;
      key_d  <= key_s;
    end
  end

  assign nedge = key_d & ~key_s;
  assign pedge = ~key_d & key_s;

  // Arm press detection only once a real synchronized sample shows the key released.
  // The synchronizer is preset to 1, so a key held down through reset release would
  // otherwise look like a fresh falling edge two clocks later. boot_q marks the
  // point where key_s starts carrying real key_in samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q <= 2'b00;
      armed  <= 1'b0;
    end else begin
      boot_q <= {boot_q[0], 1'b1};
      armed  <= armed | (boot_q[1] & key_s);
    end
  end

  // FSM state, debounce counter and registered flag/level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      key_flag  <= flag_nx;
      key_state <= kstate_nx;
    end
  end

  // Next-state logic: a level must hold for the whole filter window before it is accepted.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    flag_nx   = 1'b0;
    kstate_nx = key_state;
    case (state)
      IDLE: begin
        if (nedge && armed) begin
          state_nx = FILTER0;
          cnt_nx   = '0;
        end
      end
      FILTER0: begin
        if (pedge) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (!key_s && cnt == CNT_LAST) begin
          state_nx  = DOWN;
          cnt_nx    = '0;
          flag_nx   = 1'b1;
          kstate_nx = 1'b0;
        end else if (!key_s) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (pedge) begin
          state_nx = FILTER1;
          cnt_nx   = '0;
        end
      end
      FILTER1: begin
        if (nedge) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (key_s && cnt == CNT_LAST) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          flag_nx   = 1'b1;
          kstate_nx = 1'b1;
        end else if (key_s) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign state_dbg = state;

  // A press is a flag that drove the debounced level low; releases never start en.
  assign press = key_flag & ~key_state;

  // en counter: reload on every press, so a retrigger extends the strobe with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cnt <= '0;
    end else if (press) begin
      en_cnt <= EN_LOAD;
    end else if (en_cnt != 4'd0) begin
      en_cnt <= en_cnt - 4'd1;
    end
  end

  assign en = (en_cnt != 4'd0);

  // Saturating press counter, stepped on the same edge that raises en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt <= 8'd0;
    end else if (press && press_cnt != 8'hFF) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_en_gen.sv
// Testbench for key_en_gen: reset checks, a table of key waveforms with expected
// event counts, hand-written bounce / mid-operation reset / saturation sequences,
// and random key activity compared cycle by cycle against a run-length model.
module tb_key_en_gen;
  localparam int CNT_MAX   = 5;
  localparam int CNT_W     = 20;
  localparam int EN_CYCLES = 3;
  localparam int NV        = 6;

  // ---------------- clock / reset ----------------
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       key_in = 1'b1;
  logic       en, key_flag, key_state;
  logic [7:0] press_cnt;
  logic [1:0] state_dbg;

  always #10 clk = ~clk;

  key_en_gen #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W), .EN_CYCLES(EN_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .en        (en),
    .key_flag  (key_flag),
    .key_state (key_state),
    .press_cnt (press_cnt),
    .state_dbg (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // key_s is key_in delayed by two sampling edges; a new debounced level is
  // accepted once CNT_MAX+1 consecutive synchronized samples differ from the
  // current level, starting from a real transition. Presses are only counted
  // after a genuine released sample has been seen since reset.
  bit hv_q[$];
  bit real_q[$];
  bit m_level, m_prev, m_armed, m_flag;
  int m_r, m_edge, m_last_press, m_pc;

  always @(posedge clk or negedge rst_n) begin
    bit ks, kr;
    if (!rst_n) begin
      hv_q         = '{1'b1, 1'b1};
      real_q       = '{1'b0, 1'b0};
      m_level      = 1'b1;
      m_prev       = 1'b1;
      m_armed      = 1'b0;
      m_flag       = 1'b0;
      m_r          = 0;
      m_edge       = 0;
      m_last_press = -100;
      m_pc         = 0;
    end else begin
      m_edge++;
      if (m_last_press == m_edge - 1 && m_pc < 255) m_pc++;
      ks = hv_q.pop_front();
      kr = real_q.pop_front();
      hv_q.push_back(key_in);
      real_q.push_back(1'b1);
      m_flag = 1'b0;
      if (ks != m_level) begin
        if (m_r > 0) m_r++;
        else if (m_armed && m_prev == m_level) m_r = 1;
      end else begin
        m_r = 0;
      end
      if (m_r == CNT_MAX + 1) begin
        m_level = ~m_level;
        m_flag  = 1'b1;
        m_r     = 0;
        if (!m_level) m_last_press = m_edge;
      end
      if (kr && ks) m_armed = 1'b1;
      m_prev = ks;
    end
  end

  function automatic bit model_en();
    int d;
    d = m_edge - m_last_press;
    return (d >= 1 && d <= EN_CYCLES);
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mdl_key_flag",  32'(key_flag),  32'(m_flag));
      check("mdl_key_state", 32'(key_state), 32'(m_level));
      check("mdl_en",        32'(en),        32'(model_en()));
      check("mdl_press_cnt", 32'(press_cnt), 32'(m_pc));
    end
  end

  // ---------------- event monitor ----------------
  int n_press = 0, n_rel = 0, n_en = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_flag && !key_state) n_press++;
      if (key_flag && key_state)  n_rel++;
      if (en)                     n_en++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int low1;
    int high1;
    int low2;
    int high2;
    int exp_press;
    int exp_rel;
    int exp_en;
  } vec_t;

  vec_t vecs[NV];

  // ---------------- main sequence ----------------
  initial begin
    int p0, r0, e0, exp_pc;
    bit ok;

    vecs[0] = '{20, 20,  0,  0, 1, 1, 3};  // clean press and release
    vecs[1] = '{ 3, 20,  0,  0, 0, 0, 0};  // short glitch
    vecs[2] = '{ 4, 20,  0,  0, 0, 0, 0};  // glitch just under the window
    vecs[3] = '{ 8, 20,  0,  0, 1, 1, 3};  // press just past the window
    vecs[4] = '{20,  3, 20, 20, 1, 1, 3};  // release glitch while held down
    vecs[5] = '{10, 15, 10, 15, 2, 2, 6};  // two separate presses

    // Asynchronous reset: outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    #3;
    check("rst_en",        32'(en),        32'd0);
    check("rst_key_flag",  32'(key_flag),  32'd0);
    check("rst_key_state", 32'(key_state), 32'd1);
    check("rst_press_cnt", 32'(press_cnt), 32'd0);
    check("rst_state",     32'(state_dbg), 32'd0);
    #57 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 5);
    exp_pc = 0;

    // Table-driven key waveforms.
    for (int i = 0; i < NV; i++) begin
      p0 = n_press; r0 = n_rel; e0 = n_en;
      drive(1'b0, vecs[i].low1);
      drive(1'b1, vecs[i].high1);
      drive(1'b0, vecs[i].low2);
      drive(1'b1, vecs[i].high2);
      drive(1'b1, 20);
      exp_pc += vecs[i].exp_press;
      check($sformatf("v%0d_press", i), 32'(n_press - p0), 32'(vecs[i].exp_press));
      check($sformatf("v%0d_rel", i),   32'(n_rel - r0),   32'(vecs[i].exp_rel));
      check($sformatf("v%0d_en", i),    32'(n_en - e0),    32'(vecs[i].exp_en));
      check($sformatf("v%0d_idle", i),  32'(state_dbg),    32'd0);
      check($sformatf("v%0d_pcnt", i),  32'(press_cnt),    32'(exp_pc));
    end

    // Bounce: toggle every 2 clocks for 12 clocks, then hold low.
    p0 = n_press; e0 = n_en;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2);
      drive(1'b1, 2);
    end
    drive(1'b0, 10);
    drive(1'b1, 20);
    exp_pc += 1;
    check("bounce_press", 32'(n_press - p0), 32'd1);
    check("bounce_en",    32'(n_en - e0),    32'd3);
    check("bounce_pcnt",  32'(press_cnt),    32'(exp_pc));

    // Random key activity, checked by the model every cycle.
    for (int i = 0; i < 150; i++) begin
      drive(1'(i % 2 == 0 ? 0 : 1), $urandom_range(1, 12));
    end
    drive(1'b1, 30);

    // Reset during the second clock of an en pulse, key still held down.
    key_in = 1'b0;
    wait_en(40, ok);
    check("midrst_en_rise", 32'(ok), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_en",        32'(en),        32'd0);
    check("midrst_press_cnt", 32'(press_cnt), 32'd0);
    check("midrst_key_state", 32'(key_state), 32'd1);
    check("midrst_state",     32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = n_press; e0 = n_en;
    drive(1'b0, 30);
    check("held_no_press", 32'(n_press - p0), 32'd0);
    check("held_no_en",    32'(n_en - e0),    32'd0);
    drive(1'b1, 20);
    drive(1'b0, 20);
    drive(1'b1, 20);
    check("rearm_press", 32'(n_press - p0), 32'd1);
    check("rearm_pcnt",  32'(press_cnt),    32'd1);
    exp_pc = 1;

    // Saturation: 260 clean presses; the counter must stop at 255.
    p0 = n_press; e0 = n_en;
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 10);
      drive(1'b1, 10);
    end
    drive(1'b1, 20);
    check("sat_press", 32'(n_press - p0), 32'd260);
    check("sat_en",    32'(n_en - e0),    32'(260 * EN_CYCLES));
    check("sat_pcnt",  32'(press_cnt),    32'd255);
    drive(1'b0, 10);
    drive(1'b1, 20);
    check("sat_hold",  32'(press_cnt),    32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
